// File: rtl/alu_pkg.sv
// Shared constants for ALU control decode and the multiply/divide unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: funct codes, ALU control codes, ALUOp codes, md FSM state encoding,
//           and a helper that classifies HI/LO instructions.
package alu_pkg;

  // R-type funct field values
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  // ALU control codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_BAD = 4'b1111;

  // ALUOp codes from main control
  localparam logic [1:0] ALUOP_LDST = 2'b00;
  localparam logic [1:0] ALUOP_BR   = 2'b01;
  localparam logic [1:0] ALUOP_R    = 2'b10;
  localparam logic [1:0] ALUOP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_t;

  // True for the eight instructions that touch HI/LO.
  function automatic logic is_md_funct(input logic [5:0] f);
    logic r;
    case (f)
      F_MULT, F_MULTU, F_DIV, F_DIVU,
      F_MFHI, F_MTHI, F_MFLO, F_MTLO: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) datapath.
// Latency: DATA_W step cycles after load; result valid once last step completes.
// Backpressure: none; caller sequences load/step.
// Ports: clk, rst (sync, active-high); load/is_div/opa/opb start an operation;
//        step advances one iteration; res_hi/res_lo = {product} or {remainder, quotient};
//        last is high while the final iteration is being performed.
module md_iter_core
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  output logic [DATA_W-1:0] res_hi,
  output logic [DATA_W-1:0] res_lo,
  output logic              last
);

  logic [DATA_W-1:0] acc;   // partial product high half / partial remainder
  logic [DATA_W-1:0] sreg;  // multiplier shifting out / dividend shifting into quotient
  logic [DATA_W-1:0] opnd;  // multiplicand / divisor
  logic              div_mode;
  logic [CNT_W-1:0]  cnt;

  logic [DATA_W:0] mul_sum;
  logic [DATA_W:0] div_shift;
  logic [DATA_W:0] div_diff;

  always_comb begin
    mul_sum   = {1'b0, acc} + (sreg[0] ? {1'b0, opnd} : '0);
    div_shift = {acc, sreg[DATA_W-1]};
    // acc < opnd always holds, so a set top bit here means the subtract borrowed.
    div_diff  = div_shift - {1'b0, opnd};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      sreg     <= '0;
      opnd     <= '0;
      div_mode <= 1'b0;
      cnt      <= '0;
    end else if (load) begin
      acc      <= '0;
      sreg     <= opa;
      opnd     <= opb;
      div_mode <= is_div;
      cnt      <= '0;
    end else if (step) begin
      cnt <= cnt + CNT_W'(1);
      if (div_mode) begin
        if (!div_diff[DATA_W]) begin
          acc  <= div_diff[DATA_W-1:0];
          sreg <= {sreg[DATA_W-2:0], 1'b1};
        end else begin
          acc  <= div_shift[DATA_W-1:0];
          sreg <= {sreg[DATA_W-2:0], 1'b0};
        end
      end else begin
        acc  <= mul_sum[DATA_W:1];
        sreg <= {mul_sum[0], sreg[DATA_W-1:1]};
      end
    end
  end

  assign res_hi = acc;
  assign res_lo = sreg;
  assign last   = (cnt == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/alu_ctrl_md.sv
// ALU control decode plus multi-cycle multiply/divide unit with HI/LO registers.
// Latency: decode combinational; mult/div busy DATA_W+1 cycles (1 for divide by zero).
// Backpressure: stall holds any HI/LO instruction in decode while a mult/div is in flight.
// Ports: clk, rst (sync, active-high); valid_in/alu_op/funct/rs_val/rt_val from decode;
//        alu_ctrl/illegal decode result; stall to pipeline; md_rdata for MFHI/MFLO;
//        busy, md_done and div0 status.
module alu_ctrl_md
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic [3:0]        alu_ctrl,
  output logic              illegal,
  output logic              stall,
  output logic [DATA_W-1:0] md_rdata,
  output logic              busy,
  output logic              md_done,
  output logic              div0
);

  md_state_t         state;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] rs_hold;   // raw dividend, returned in HI on divide by zero
  logic              op_div;
  logic              neg_q;     // quotient / product must be negated
  logic              neg_r;     // remainder must be negated (dividend sign)

  // ---------------- decode ----------------
  always_comb begin
    alu_ctrl = ALU_BAD;
    illegal  = 1'b0;
    case (alu_op)
      ALUOP_LDST: alu_ctrl = ALU_ADD;
      ALUOP_BR:   alu_ctrl = ALU_SUB;
      ALUOP_R: begin
        case (funct)
          F_AND: alu_ctrl = ALU_AND;
          F_OR:  alu_ctrl = ALU_OR;
          F_ADD: alu_ctrl = ALU_ADD;
          F_SUB: alu_ctrl = ALU_SUB;
          F_SLT: alu_ctrl = ALU_SLT;
          F_NOR: alu_ctrl = ALU_NOR;
          F_MULT, F_MULTU, F_DIV, F_DIVU,
          F_MFHI, F_MTHI, F_MFLO, F_MTLO: alu_ctrl = ALU_ADD;
          default: begin
            alu_ctrl = ALU_BAD;
            illegal  = 1'b1;
          end
        endcase
      end
      default: begin
        alu_ctrl = ALU_BAD;
        illegal  = 1'b1;
      end
    endcase
  end

  logic r_type, md_cls, accept;
  logic is_arith, is_div_f, is_signed_f;
  logic sa, sb;
  logic [DATA_W-1:0] mag_a, mag_b;

  assign busy   = (state != ST_IDLE);
  assign r_type = (alu_op == ALUOP_R);
  assign md_cls = r_type & is_md_funct(funct);
  assign stall  = valid_in & md_cls & busy;
  assign accept = valid_in & md_cls & ~busy;

  assign is_arith    = (funct == F_MULT) | (funct == F_MULTU) | (funct == F_DIV) | (funct == F_DIVU);
  assign is_div_f    = (funct == F_DIV)  | (funct == F_DIVU);
  assign is_signed_f = (funct == F_MULT) | (funct == F_DIV);

  // Signed ops run on magnitudes; the signs are reapplied in FIX.
  assign sa    = is_signed_f & rs_val[DATA_W-1];
  assign sb    = is_signed_f & rt_val[DATA_W-1];
  assign mag_a = sa ? -rs_val : rs_val;
  assign mag_b = sb ? -rt_val : rt_val;

  always_comb begin
    md_rdata = '0;
    if (r_type && funct == F_MFHI) md_rdata = hi;
    else if (r_type && funct == F_MFLO) md_rdata = lo;
  end

  // ---------------- iterative datapath ----------------
  logic [DATA_W-1:0] res_hi, res_lo;
  logic              core_last;

  md_iter_core #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (accept & is_arith),
    .step   (state == ST_RUN),
    .is_div (is_div_f),
    .opa    (mag_a),
    .opb    (mag_b),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .last   (core_last)
  );

  // Sign fixup. MIN / -1 needs no special case: the magnitude quotient is
  // 2**(DATA_W-1), and with no negation it already reads back as MIN.
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   q_fix, r_fix, fix_hi, fix_lo;

  always_comb begin
    prod_fix = neg_q ? -{res_hi, res_lo} : {res_hi, res_lo};
    q_fix    = neg_q ? -res_lo : res_lo;
    r_fix    = neg_r ? -res_hi : res_hi;
    fix_hi   = op_div ? r_fix : prod_fix[2*DATA_W-1:DATA_W];
    fix_lo   = op_div ? q_fix : prod_fix[DATA_W-1:0];
  end

  // ---------------- FSM, HI/LO ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      hi      <= '0;
      lo      <= '0;
      rs_hold <= '0;
      op_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      md_done <= 1'b0;
      div0    <= 1'b0;
    end else begin
      md_done <= 1'b0;
      div0    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (funct == F_MTHI) hi <= rs_val;
            if (funct == F_MTLO) lo <= rs_val;
            if (is_arith) begin
              op_div  <= is_div_f;
              neg_q   <= sa ^ sb;
              neg_r   <= sa;
              rs_hold <= rs_val;
              state   <= (is_div_f && rt_val == '0) ? ST_DONE : ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (core_last) state <= ST_FIX;
        end
        ST_FIX: begin
          hi      <= fix_hi;
          lo      <= fix_lo;
          md_done <= 1'b1;
          state   <= ST_IDLE;
        end
        ST_DONE: begin
          hi      <= rs_hold;
          lo      <= '1;
          md_done <= 1'b1;
          div0    <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_md.sv
module tb_alu_ctrl_md;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] rs_val, rt_val;
  logic [3:0]  alu_ctrl;
  logic        illegal, stall, busy, md_done, div0;
  logic [31:0] md_rdata;

  int checks = 0;
  int errors = 0;

  alu_ctrl_md #(.DATA_W(32), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .alu_op   (alu_op),
    .funct    (funct),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .alu_ctrl (alu_ctrl),
    .illegal  (illegal),
    .stall    (stall),
    .md_rdata (md_rdata),
    .busy     (busy),
    .md_done  (md_done),
    .div0     (div0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] exp_ctrl;
    logic       exp_ill;
  } dec_vec_t;

  dec_vec_t vecs [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // Read HI and LO through MFHI/MFLO with valid_in low (no accept).
  task automatic chk_hilo(input string name, input logic [31:0] ehi, input logic [31:0] elo);
    valid_in = 1'b0;
    alu_op   = 2'b10;
    funct    = F_MFHI;
    #1 chk({name, ".hi"}, 64'(md_rdata), 64'(ehi));
    funct = F_MFLO;
    #1 chk({name, ".lo"}, 64'(md_rdata), 64'(elo));
  endtask

  // Issue one mult/div, count busy cycles, then check done flags and HI/LO.
  task automatic run_md(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cyc, input logic exp_div0,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    @(negedge clk);
    valid_in = 1'b1; alu_op = 2'b10; funct = f; rs_val = a; rt_val = b;
    @(negedge clk);
    valid_in = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk({name, ".busy_cycles"}, 64'(n), 64'(exp_cyc));
    chk({name, ".md_done"}, 64'(md_done), 64'd1);
    chk({name, ".div0"}, 64'(div0), 64'(exp_div0));
    chk_hilo(name, ehi, elo);
    @(negedge clk);
    chk({name, ".done_pulse"}, 64'(md_done), 64'd0);
  endtask

  initial begin
    int n;
    logic stall_ok;

    vecs[0]  = '{2'b10, 6'b100100, 4'b0000, 1'b0};
    vecs[1]  = '{2'b10, 6'b100101, 4'b0001, 1'b0};
    vecs[2]  = '{2'b10, 6'b100000, 4'b0010, 1'b0};
    vecs[3]  = '{2'b10, 6'b100010, 4'b0110, 1'b0};
    vecs[4]  = '{2'b10, 6'b101010, 4'b0111, 1'b0};
    vecs[5]  = '{2'b10, 6'b100111, 4'b1100, 1'b0};
    vecs[6]  = '{2'b10, 6'b000000, 4'b1111, 1'b1};
    vecs[7]  = '{2'b10, 6'b011000, 4'b0010, 1'b0};
    vecs[8]  = '{2'b10, 6'b010000, 4'b0010, 1'b0};
    vecs[9]  = '{2'b10, 6'b010011, 4'b0010, 1'b0};
    vecs[10] = '{2'b10, 6'b101111, 4'b1111, 1'b1};
    vecs[11] = '{2'b00, 6'b101010, 4'b0010, 1'b0};
    vecs[12] = '{2'b01, 6'b100100, 4'b0110, 1'b0};
    vecs[13] = '{2'b11, 6'b100000, 4'b1111, 1'b1};

    rst = 1'b1; valid_in = 1'b0; alu_op = 2'b00; funct = 6'd0; rs_val = '0; rt_val = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.md_done", 64'(md_done), 64'd0);
    chk("rst.div0", 64'(div0), 64'd0);
    chk_hilo("rst", 32'h0, 32'h0);

    // decode table
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      valid_in = 1'b0; alu_op = vecs[i].op; funct = vecs[i].fn;
      #1;
      chk($sformatf("dec%0d.ctrl", i), 64'(alu_ctrl), 64'(vecs[i].exp_ctrl));
      chk($sformatf("dec%0d.illegal", i), 64'(illegal), 64'(vecs[i].exp_ill));
    end

    // multiply / divide results
    run_md("mult", F_MULT, 32'hFFFFFFFD, 32'd7, 33, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_md("multu", F_MULTU, 32'hFFFFFFFF, 32'd2, 33, 1'b0, 32'h00000001, 32'hFFFFFFFE);
    run_md("div", F_DIV, 32'hFFFFFFF9, 32'd2, 33, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md("divu", F_DIVU, 32'd100, 32'd7, 33, 1'b0, 32'd2, 32'd14);
    run_md("divmin", F_DIV, 32'h80000000, 32'hFFFFFFFF, 33, 1'b0, 32'h0, 32'h80000000);
    run_md("div0", F_DIVU, 32'd5, 32'd0, 1, 1'b1, 32'd5, 32'hFFFFFFFF);

    // MFLO three cycles after MULT: stalled until busy drops
    @(negedge clk);
    valid_in = 1'b1; alu_op = 2'b10; funct = F_MULT; rs_val = 32'd6; rt_val = 32'd7;
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    valid_in = 1'b1; funct = F_MFLO;
    #1 chk("mflo.stall_first", 64'(stall), 64'd1);
    stall_ok = 1'b1;
    n = 0;
    while (busy && n < 200) begin
      if (!stall) stall_ok = 1'b0;
      n++;
      @(negedge clk);
      #1;
    end
    chk("mflo.stall_held", 64'(stall_ok), 64'd1);
    chk("mflo.stall_cycles", 64'(n), 64'd31);
    chk("mflo.stall_release", 64'(stall), 64'd0);
    chk("mflo.rdata", 64'(md_rdata), 64'd42);
    @(negedge clk);
    valid_in = 1'b0;

    // MTHI while idle
    @(negedge clk);
    valid_in = 1'b1; alu_op = 2'b10; funct = F_MTHI; rs_val = 32'h1234ABCD;
    @(negedge clk);
    valid_in = 1'b0;
    chk("mthi.busy", 64'(busy), 64'd0);
    chk("mthi.md_done", 64'(md_done), 64'd0);
    chk_hilo("mthi", 32'h1234ABCD, 32'd42);

    // MTLO while busy is stalled and must not overwrite the result
    @(negedge clk);
    valid_in = 1'b1; alu_op = 2'b10; funct = F_MULTU; rs_val = 32'h00010000; rt_val = 32'h00030000;
    @(negedge clk);
    funct = F_MTLO; rs_val = 32'hDEADBEEF;
    #1 chk("mtlo_busy.stall", 64'(stall), 64'd1);
    @(negedge clk);
    valid_in = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("mtlo_busy.done", 64'(md_done), 64'd1);
    chk_hilo("mtlo_busy", 32'h00000003, 32'h00000000);

    // reset in the middle of RUN
    @(negedge clk);
    valid_in = 1'b1; alu_op = 2'b10; funct = F_MULT; rs_val = 32'd9; rt_val = 32'd9;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst.busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.md_done", 64'(md_done), 64'd0);
    chk_hilo("midrst", 32'h0, 32'h0);
    repeat (40) @(negedge clk);
    chk("midrst.no_late_done", 64'(md_done), 64'd0);
    run_md("after_rst", F_MULT, 32'hFFFFFFF6, 32'hFFFFFFFD, 33, 1'b0, 32'h0, 32'd30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
